// File: rtl/burst_ext_device_pkg.sv
// Shared types and constants for the burst external device: FSM states, default geometry
// and the refresh LFSR definition.
package burst_ext_device_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StIrq,
        StXfer
    } state_e;

    localparam int unsigned DefWordSize = 16;
    localparam int unsigned DefBurstLen = 4;
    localparam int unsigned DefDepth    = 3;

    localparam logic [15:0] LfsrSeed    = 16'hACE1;
    // Right-shifting Fibonacci form: taps 16,14,13,11 feed back from bits 0,2,3,5.
    localparam logic [15:0] LfsrTapMask = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LfsrTapMask), s[15:1]};
    endfunction

endpackage

// File: rtl/burst_lfsr16.sv
// 16-bit Fibonacci LFSR that supplies refresh data; steps only when enabled.
module burst_lfsr16
    import burst_ext_device_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [15:0] value
);

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LfsrSeed;
        end else if (enable) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign value = state_q;

endmodule

// File: rtl/burst_ext_device.sv
// Timer-armed burst device: after FIRE_PERIOD cycles it raises an interrupt, serves line reads,
// and on completion refreshes every storage word from an LFSR.
module burst_ext_device
    import burst_ext_device_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DefWordSize,
    parameter int unsigned BURST_LEN   = DefBurstLen,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned FIRE_PERIOD = 4290,
    parameter int unsigned AUTO_REARM  = 1,
    parameter int unsigned OFS_W       = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [OFS_W-1:0]               offset,
    input  logic                           rd_en,
    input  logic                           intr_ack,
    input  logic                           load_en,
    input  logic [OFS_W-1:0]               load_addr,
    input  logic [BURST_LEN*WORD_SIZE-1:0] load_data,
    output logic                           interrupt,
    output logic [BURST_LEN*WORD_SIZE-1:0] data,
    output logic                           data_valid,
    output logic                           rd_err,
    output logic                           done,
    output logic                           busy
);

    localparam int unsigned LineW = BURST_LEN * WORD_SIZE;
    localparam int unsigned CntW  = $clog2(FIRE_PERIOD + 1);
    localparam int unsigned WordW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CntW-1:0]  Reload   = CntW'(FIRE_PERIOD - 1);
    localparam logic [OFS_W-1:0] LastLine = OFS_W'(DEPTH - 1);
    localparam logic [WordW-1:0] LastWord = WordW'(BURST_LEN - 1);

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [DEPTH-1:0]   served_q;
    logic               refresh_q;
    logic [OFS_W-1:0]   ref_line_q;
    logic [WordW-1:0]   ref_word_q;
    logic               interrupt_q;
    logic [LineW-1:0]   data_q;
    logic               data_valid_q;
    logic               rd_err_q;
    logic               done_q;
    logic               busy_q;
    logic [LineW-1:0]   mem_q [DEPTH];

    logic               rd_ok;
    logic               rd_hit;
    logic               done_evt;
    logic               ref_last;
    logic               lfsr_en;
    logic [DEPTH-1:0]   served_nxt;
    logic [15:0]        lfsr_value;

    always_comb begin
        rd_ok      = 32'(offset) < DEPTH;
        rd_hit     = (state_q == StXfer) && !refresh_q && rd_en;
        served_nxt = served_q | (DEPTH'(1) << offset);
        done_evt   = rd_hit && rd_ok && (&served_nxt);
        ref_last   = (ref_line_q == LastLine) && (ref_word_q == LastWord);
        // Step once on done so the first refresh word is already one past the current value.
        lfsr_en    = done_evt || (refresh_q && !ref_last);
    end

    burst_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (lfsr_en),
        .value   (lfsr_value)
    );

    // Storage has no reset so preloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (refresh_q) begin
            mem_q[ref_line_q][32'(ref_word_q)*WORD_SIZE +: WORD_SIZE] <= WORD_SIZE'(lfsr_value);
        end else if (load_en && (32'(load_addr) < DEPTH)) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            served_q     <= '0;
            refresh_q    <= 1'b0;
            ref_line_q   <= '0;
            ref_word_q   <= '0;
            interrupt_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StWait;
                        cnt_q   <= Reload;
                        busy_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StIrq;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StIrq: begin
                    if (interrupt_q && intr_ack) begin
                        interrupt_q <= 1'b0;
                        state_q     <= StXfer;
                    end else begin
                        interrupt_q <= 1'b1;
                    end
                end
                StXfer: begin
                    if (refresh_q) begin
                        if (ref_last) begin
                            refresh_q  <= 1'b0;
                            ref_line_q <= '0;
                            ref_word_q <= '0;
                            if (AUTO_REARM != 0) begin
                                state_q <= StWait;
                                cnt_q   <= Reload;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else if (ref_word_q == LastWord) begin
                            ref_word_q <= '0;
                            ref_line_q <= ref_line_q + 1'b1;
                        end else begin
                            ref_word_q <= ref_word_q + 1'b1;
                        end
                    end else if (rd_hit) begin
                        if (rd_ok) begin
                            data_q       <= mem_q[offset];
                            data_valid_q <= 1'b1;
                            if (done_evt) begin
                                done_q    <= 1'b1;
                                served_q  <= '0;
                                refresh_q <= 1'b1;
                            end else begin
                                served_q <= served_nxt;
                            end
                        end else begin
                            data_q   <= '0;
                            rd_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign interrupt  = interrupt_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign rd_err     = rd_err_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_burst_ext_device.sv
// Directed bench for burst_ext_device: one instance without auto re-arm, one with.
module tb_burst_ext_device;

    localparam int unsigned WS = 16;
    localparam int unsigned BL = 4;
    localparam int unsigned DP = 3;
    localparam int unsigned FP = 10;
    localparam int unsigned OW = 2;
    localparam int unsigned LW = WS * BL;

    localparam logic [LW-1:0] L0 = 64'h1111_2222_3333_4444;
    localparam logic [LW-1:0] L1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [LW-1:0] L2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [LW-1:0] N0 = 64'h5555_6666_7777_8888;
    localparam logic [LW-1:0] P0 = 64'hA0A0_B1B1_C2C2_D3D3;
    localparam logic [LW-1:0] P1 = 64'h0F0F_1E1E_2D2D_3C3C;
    localparam logic [LW-1:0] P2 = 64'h9876_5432_10FE_DCBA;

    logic clk = 1'b0;
    logic rst1_n, rst2_n, start, rd_en, intr_ack, load_en, sel;
    logic [OW-1:0] offset, load_addr;
    logic [LW-1:0] load_data;
    logic int1, int2, dv1, dv2, err1, err2, done1, done2, busy1, busy2;
    logic [LW-1:0] data1, data2;
    logic m_int, m_dv, m_err, m_done, m_busy;
    logic [LW-1:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          rd;
        logic [OW-1:0] ofs;
        logic          ld;
        logic [OW-1:0] la;
        logic [LW-1:0] ldata;
        logic [LW-1:0] edata;
        logic          ev;
        logic          ee;
        logic          ed;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] words [BL*DP];

    always #5 clk = ~clk;

    assign m_int  = sel ? int2  : int1;
    assign m_dv   = sel ? dv2   : dv1;
    assign m_err  = sel ? err2  : err1;
    assign m_done = sel ? done2 : done1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_data = sel ? data2 : data1;

    burst_ext_device #(
        .WORD_SIZE(WS), .BURST_LEN(BL), .DEPTH(DP), .FIRE_PERIOD(FP), .AUTO_REARM(0), .OFS_W(OW)
    ) dut (
        .clk(clk), .reset_n(rst1_n), .start(start), .offset(offset), .rd_en(rd_en),
        .intr_ack(intr_ack), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .interrupt(int1), .data(data1), .data_valid(dv1), .rd_err(err1), .done(done1),
        .busy(busy1)
    );

    burst_ext_device #(
        .WORD_SIZE(WS), .BURST_LEN(BL), .DEPTH(DP), .FIRE_PERIOD(FP), .AUTO_REARM(1), .OFS_W(OW)
    ) dut_ar (
        .clk(clk), .reset_n(rst2_n), .start(start), .offset(offset), .rd_en(rd_en),
        .intr_ack(intr_ack), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .interrupt(int2), .data(data2), .data_valid(dv2), .rd_err(err2), .done(done2),
        .busy(busy2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [LW-1:0] line_of(input int l);
        logic [LW-1:0] v;
        for (int w = 0; w < BL; w++) v[w*WS +: WS] = words[l*BL + w];
        return v;
    endfunction

    task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [OW-1:0] a, input logic [LW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic start_to_irq(input string name);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_b({name, "_busy"}, m_busy, 1'b1);
        n = 0;
        while (m_int !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_w({name, "_irq_delay"}, 64'(n), 64'd11);
    endtask

    task automatic ack_irq(input string name);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        check_b({name, "_irq_drop"}, m_int, 1'b0);
    endtask

    task automatic rd(input string name, input logic [OW-1:0] ofs, input logic [LW-1:0] ed,
                      input logic ev, input logic ee, input logic edn);
        rd_en = 1'b1; offset = ofs;
        tick();
        rd_en = 1'b0;
        check_w({name, "_data"}, m_data, ed);
        check_b({name, "_valid"}, m_dv, ev);
        check_b({name, "_err"}, m_err, ee);
        check_b({name, "_done"}, m_done, edn);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (m_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check_b({name, "_idle"}, m_busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [15:0] s;

        s = 16'hACE1;
        for (int k = 0; k < BL*DP; k++) begin
            s = lfsr_step(s);
            words[k] = s;
        end

        vecs[0] = '{1'b1, 2'd1, 1'b0, 2'd0, '0, L1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 1'b0, 2'd0, '0, L1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 1'b0, 2'd0, '0, '0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 1'b1, 2'd0, N0, L0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 1'b0, 2'd0, '0, L1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'd0, 1'b0, 2'd0, '0, N0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 1'b0, 2'd0, '0, L2, 1'b1, 1'b0, 1'b1};

        sel = 1'b0; start = 1'b0; rd_en = 1'b0; intr_ack = 1'b0; load_en = 1'b0;
        offset = '0; load_addr = '0; load_data = '0;
        rst1_n = 1'b1; rst2_n = 1'b1;
        #2;
        rst1_n = 1'b0; rst2_n = 1'b0;
        #2;
        check_b("rst_int", m_int, 1'b0);
        check_w("rst_data", m_data, '0);
        check_b("rst_valid", m_dv, 1'b0);
        check_b("rst_err", m_err, 1'b0);
        check_b("rst_done", m_done, 1'b0);
        check_b("rst_busy", m_busy, 1'b0);
        tick();
        tick();
        rst1_n = 1'b1;

        load(2'd0, L0);
        load(2'd1, L1);
        load(2'd2, L2);

        // First arm: start, ack and reads issued during WAIT must all be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_b("t1_busy", m_busy, 1'b1);
        n = 0;
        while (m_int !== 1'b1 && n < 40) begin
            start = (n == 3); intr_ack = (n == 5); rd_en = (n == 6); offset = 2'd0;
            tick();
            n++;
            if (n == 7) begin
                check_b("wait_rd_valid", m_dv, 1'b0);
                check_b("wait_rd_err", m_err, 1'b0);
                check_w("wait_rd_data", m_data, '0);
            end
        end
        start = 1'b0; intr_ack = 1'b0; rd_en = 1'b0;
        check_w("t1_irq_delay", 64'(n), 64'd11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_b("irq_hold", m_int, 1'b1);
        end
        ack_irq("t1");

        for (int i = 0; i < 8; i++) begin
            rd_en = vecs[i].rd; offset = vecs[i].ofs;
            load_en = vecs[i].ld; load_addr = vecs[i].la; load_data = vecs[i].ldata;
            tick();
            rd_en = 1'b0; load_en = 1'b0;
            check_w($sformatf("vec%0d_data", i), m_data, vecs[i].edata);
            check_b($sformatf("vec%0d_valid", i), m_dv, vecs[i].ev);
            check_b($sformatf("vec%0d_err", i), m_err, vecs[i].ee);
            check_b($sformatf("vec%0d_done", i), m_done, vecs[i].ed);
        end

        // Refresh: busy stays high, reads are ignored, done pulses only once.
        rd_en = 1'b1; offset = 2'd0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check_b($sformatf("ref%0d_busy", i), m_busy, 1'b1);
            check_b($sformatf("ref%0d_valid", i), m_dv, 1'b0);
            check_b($sformatf("ref%0d_done", i), m_done, 1'b0);
        end
        rd_en = 1'b0;
        tick();
        check_b("ref_end_idle", m_busy, 1'b0);

        start_to_irq("t2");
        ack_irq("t2");
        rd("t2_l0", 2'd0, line_of(0), 1'b1, 1'b0, 1'b0);
        check_w("lfsr_first", 64'(m_data[15:0]), 64'h5670);
        rd("t2_l1", 2'd1, line_of(1), 1'b1, 1'b0, 1'b0);
        rd("t2_l2", 2'd2, line_of(2), 1'b1, 1'b0, 1'b1);
        wait_idle("t2");

        // Reset while interrupt is high: abandoned transfer, storage and LFSR seed restored.
        load(2'd0, P0);
        load(2'd1, P1);
        load(2'd2, P2);
        start_to_irq("t3");
        rst1_n = 1'b0;
        #1;
        check_b("mid_rst_int", m_int, 1'b0);
        check_b("mid_rst_busy", m_busy, 1'b0);
        check_b("mid_rst_done", m_done, 1'b0);
        tick();
        tick();
        rst1_n = 1'b1;
        tick();
        check_b("post_rst_done", m_done, 1'b0);
        check_b("post_rst_int", m_int, 1'b0);
        start_to_irq("t4");
        ack_irq("t4");
        rd("t4_l0", 2'd0, P0, 1'b1, 1'b0, 1'b0);
        rd("t4_l1", 2'd1, P1, 1'b1, 1'b0, 1'b0);
        rd("t4_l2", 2'd2, P2, 1'b1, 1'b0, 1'b1);
        wait_idle("t4");
        start_to_irq("t5");
        ack_irq("t5");
        rd("t5_l0", 2'd0, line_of(0), 1'b1, 1'b0, 1'b0);

        // Auto re-arm instance.
        rst1_n = 1'b0;
        sel = 1'b1;
        rst2_n = 1'b1;
        tick();
        check_b("ar_rst_busy", m_busy, 1'b0);
        load(2'd0, P0);
        load(2'd1, P1);
        load(2'd2, L1);
        start_to_irq("ar");
        ack_irq("ar");
        rd("ar_l0", 2'd0, P0, 1'b1, 1'b0, 1'b0);
        rd("ar_l1", 2'd1, P1, 1'b1, 1'b0, 1'b0);
        rd("ar_l2", 2'd2, L1, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (m_int !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 12) check_b("ar_rearm_busy", m_busy, 1'b1);
        end
        check_w("ar_rearm_delay", 64'(n), 64'd23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
